// File: rtl/platform_sort_drive.sv
// platform_sort_drive
// Rotates the sorting platform from the feeder to the bin for the sensed
// colour by stepping a 4-coil motor. It then waits for the M&M to drop and
// hands off to the return stage with a one-cycle p3_on pulse.
//
// Handshake: start is a level sampled only while idle. A start with a
// one-hot colour is accepted on that clock edge: busy rises and colour_q
// latches at the same edge. busy stays high through the p3_on cycle and
// falls at the following edge. While busy is high, start and colour are
// ignored. The state register 'state' is the probe point for FSM checkers.
module platform_sort_drive #(
  parameter int PHASE_CYCLES  = 97_656,
  parameter int STEPS_PER_REV = 512,
  parameter int DWELL_CYCLES  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] colour,
  output logic [3:0] GPIO_1,
  output logic       p3_on,
  output logic [5:0] colour_q,
  output logic       busy,
  output logic       err
);

  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SW = $clog2(STEPS_PER_REV / 2 + 1);
  localparam int E  = STEPS_PER_REV / 8;

  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] STEPS_1E   = SW'(E);
  localparam logic [SW-1:0] STEPS_2E   = SW'(2 * E);
  localparam logic [SW-1:0] STEPS_3E   = SW'(3 * E);
  localparam logic [SW-1:0] STEPS_4E   = SW'(4 * E);
  localparam logic [SW-1:0] STEP_ONE   = SW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    DWELL   = 2'd2,
    HANDOFF = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] phase_cnt, phase_cnt_next;
  logic [DW-1:0] dwell_cnt, dwell_cnt_next;
  logic [SW-1:0] step_cnt, step_cnt_next;
  logic [1:0]    coil_idx, coil_idx_next;
  logic          dir_ccw, dir_ccw_next;
  logic [3:0]    coil, coil_next;
  logic          p3_next, busy_next, err_next;
  logic [5:0]    colour_q_next;

  // Travel lookup for the requested colour
  logic [SW-1:0] req_steps;
  logic          req_ccw;
  logic          colour_onehot;

  // Coil pattern for a direction and a position in its 4-entry sequence
  function automatic logic [3:0] coil_pattern(input logic ccw, input logic [1:0] idx);
    coil_pattern = ccw ? (4'b0001 << idx) : (4'b1000 >> idx);
  endfunction

  assign colour_onehot = (colour != 6'd0) && ((colour & (colour - 6'd1)) == 6'd0);

  // Map the one-hot colour to a step count and direction
  always_comb begin
    req_steps = '0;
    req_ccw   = 1'b0;
    case (colour)
      6'b000001: begin req_steps = STEPS_2E; req_ccw = 1'b0; end // red
      6'b000010: begin req_steps = STEPS_3E; req_ccw = 1'b0; end // brown
      6'b000100: begin req_steps = STEPS_4E; req_ccw = 1'b0; end // yellow
      6'b001000: begin req_steps = STEPS_3E; req_ccw = 1'b1; end // orange
      6'b010000: begin req_steps = STEPS_1E; req_ccw = 1'b1; end // blue
      6'b100000: begin req_steps = STEPS_2E; req_ccw = 1'b1; end // green
      default:   begin req_steps = '0;       req_ccw = 1'b0; end
    endcase
  end

  // Next-state and next-output logic; every register holds unless told otherwise
  always_comb begin
    state_next     = state;
    phase_cnt_next = phase_cnt;
    dwell_cnt_next = dwell_cnt;
    step_cnt_next  = step_cnt;
    coil_idx_next  = coil_idx;
    dir_ccw_next   = dir_ccw;
    coil_next      = coil;
    colour_q_next  = colour_q;
    busy_next      = busy;
    p3_next        = 1'b0;
    err_next       = 1'b0;

    case (state)
      IDLE: begin
        coil_next = 4'b0000;
        if (start) begin
          if (colour_onehot) begin
            colour_q_next  = colour;
            busy_next      = 1'b1;
            step_cnt_next  = req_steps;
            dir_ccw_next   = req_ccw;
            coil_idx_next  = 2'd0;
            phase_cnt_next = '0;
            coil_next      = coil_pattern(req_ccw, 2'd0);
            state_next     = MOVE;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      MOVE: begin
        if (phase_cnt == PHASE_LAST) begin
          phase_cnt_next = '0;
          if (step_cnt == STEP_ONE) begin
            // Last phase finished: release the coils and wait for the drop
            step_cnt_next  = '0;
            coil_next      = 4'b0000;
            dwell_cnt_next = '0;
            state_next     = DWELL;
          end else begin
            step_cnt_next = step_cnt - STEP_ONE;
            coil_idx_next = coil_idx + 2'd1;
            coil_next     = coil_pattern(dir_ccw, coil_idx + 2'd1);
          end
        end else begin
          phase_cnt_next = phase_cnt + PW'(1);
        end
      end

      DWELL: begin
        coil_next = 4'b0000;
        if (dwell_cnt == DWELL_LAST) begin
          dwell_cnt_next = '0;
          p3_next        = 1'b1;
          state_next     = HANDOFF;
        end else begin
          dwell_cnt_next = dwell_cnt + DW'(1);
        end
      end

      HANDOFF: begin
        coil_next  = 4'b0000;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        coil_next  = 4'b0000;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset de-energises the coils at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      dwell_cnt <= '0;
      step_cnt  <= '0;
      coil_idx  <= 2'd0;
      dir_ccw   <= 1'b0;
      coil      <= 4'b0000;
      colour_q  <= 6'd0;
      busy      <= 1'b0;
      p3_on     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_cnt_next;
      dwell_cnt <= dwell_cnt_next;
      step_cnt  <= step_cnt_next;
      coil_idx  <= coil_idx_next;
      dir_ccw   <= dir_ccw_next;
      coil      <= coil_next;
      colour_q  <= colour_q_next;
      busy      <= busy_next;
      p3_on     <= p3_next;
      err       <= err_next;
    end
  end

  assign GPIO_1 = coil;

endmodule
